// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard-control slice.
//   state_t        : control-transfer sequencing states
//   BR_MODE_STALL  : freeze fetch until the control transfer resolves
//   BR_MODE_PNT    : predict not-taken, squash on a taken resolve
//   ZERO_REG       : architectural $zero, never a real RAW producer
package hazard_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    CTRL_WAIT = 1'b1
  } state_t;

  localparam int          BR_MODE_STALL = 0;
  localparam int          BR_MODE_PNT   = 1;
  localparam int unsigned ZERO_REG      = 0;

endpackage

// File: rtl/hazard_raw_cmp.sv
// Combinational RAW comparator: flags a read in ID of a register that a
// later-stage instruction is about to write.
//   i_id_valid   : ID holds a real instruction
//   i_rs, i_rt   : ID source registers
//   i_uses_rs/rt : source actually read
//   i_dst_valid  : producer stage holds a real instruction
//   i_dst_wr     : producer writes the register file
//   i_dst_rd     : producer destination
//   o_raw        : RAW dependency present
module hazard_raw_cmp
  import hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            i_id_valid,
  input  logic [RA_W-1:0] i_rs,
  input  logic [RA_W-1:0] i_rt,
  input  logic            i_uses_rs,
  input  logic            i_uses_rt,
  input  logic            i_dst_valid,
  input  logic            i_dst_wr,
  input  logic [RA_W-1:0] i_dst_rd,
  output logic            o_raw
);

  logic w_dst_live;
  logic w_rs_hit;
  logic w_rt_hit;

  // Writes to $zero are discarded, so they never create a dependency.
  assign w_dst_live = i_id_valid & i_dst_valid & i_dst_wr & (i_dst_rd != RA_W'(ZERO_REG));
  assign w_rs_hit   = i_uses_rs & (i_rs == i_dst_rd);
  assign w_rt_hit   = i_uses_rt & (i_rt == i_dst_rd);
  assign o_raw      = w_dst_live & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard-control unit beside the ID stage of the 5-stage MIPS pipeline.
// Detects RAW hazards against EX/MEM, tracks HI/LO occupancy of multi-cycle
// mult/div, sequences control transfers (freeze or predict-not-taken) and
// counts PC stall cycles.
//   Clk, Reset            : clock, asynchronous active-high reset
//   ID_*                  : instruction currently in ID
//   EX_*, MEM_*           : producer qualifiers and destinations
//   Resolve_Valid/Taken   : control transfer resolved this cycle
//   PC_Stall, IF_ID_Stall : hold PC / IF-ID
//   IF_ID_Flush           : zero IF-ID on the next edge
//   ID_EX_Bubble          : insert NOP into ID-EX
//   Err_Timeout           : one-cycle pulse, resolve never arrived
//   Stall_Cycles          : saturating count of PC_Stall cycles
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int FWD_EN  = 1,
  parameter int BR_MODE = 0,
  parameter int BR_LAT  = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ID_Valid,
  input  logic [RA_W-1:0]  ID_Rs,
  input  logic [RA_W-1:0]  ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_IsCtrl,
  input  logic             ID_IsMulDiv,
  input  logic             ID_ReadsHiLo,
  input  logic             EX_Valid,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [RA_W-1:0]  EX_Rd,
  input  logic             MEM_Valid,
  input  logic             MEM_RegWrite,
  input  logic [RA_W-1:0]  MEM_Rd,
  input  logic             Resolve_Valid,
  input  logic             Resolve_Taken,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Err_Timeout,
  output logic [CNT_W-1:0] Stall_Cycles
);

  localparam int WD_LOAD = 2 * BR_LAT + 2;
  localparam int WD_W    = $clog2(WD_LOAD + 1);
  localparam int MD_W    = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  state_t            r_state;
  logic [WD_W-1:0]   r_wd_cnt;
  logic [MD_W-1:0]   r_md_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_raw_ex, w_raw_mem;
  logic w_data_hz, w_md_hz, w_taken_flush, w_timeout;
  logic w_go_wait, w_md_issue;
  logic w_pc_stall, w_ifid_stall, w_flush, w_bubble;

  hazard_raw_cmp #(.RA_W(RA_W)) u_raw_ex (
    .i_id_valid (ID_Valid),
    .i_rs       (ID_Rs),
    .i_rt       (ID_Rt),
    .i_uses_rs  (ID_UsesRs),
    .i_uses_rt  (ID_UsesRt),
    .i_dst_valid(EX_Valid),
    .i_dst_wr   (EX_RegWrite),
    .i_dst_rd   (EX_Rd),
    .o_raw      (w_raw_ex)
  );

  hazard_raw_cmp #(.RA_W(RA_W)) u_raw_mem (
    .i_id_valid (ID_Valid),
    .i_rs       (ID_Rs),
    .i_rt       (ID_Rt),
    .i_uses_rs  (ID_UsesRs),
    .i_uses_rt  (ID_UsesRt),
    .i_dst_valid(MEM_Valid),
    .i_dst_wr   (MEM_RegWrite),
    .i_dst_rd   (MEM_Rd),
    .o_raw      (w_raw_mem)
  );

  assign w_data_hz     = (FWD_EN != 0) ? (w_raw_ex & EX_MemRead) : (w_raw_ex | w_raw_mem);
  assign w_md_hz       = ID_Valid & (ID_IsMulDiv | ID_ReadsHiLo) & (r_md_cnt != '0);
  assign w_taken_flush = (BR_MODE == BR_MODE_PNT) & Resolve_Valid & Resolve_Taken;

  // The watchdog fires in the cycle whose decrement would land on 1, so the
  // pulse appears 2*BR_LAT+1 cycles after issue.
  assign w_timeout = (r_state == CTRL_WAIT) & ~Resolve_Valid & (r_wd_cnt == WD_W'(2));

  always_comb begin
    w_pc_stall   = 1'b0;
    w_ifid_stall = 1'b0;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;
    w_go_wait    = 1'b0;
    w_md_issue   = 1'b0;
    if ((r_state == CTRL_WAIT) && (BR_MODE == BR_MODE_STALL)) begin
      // Fetch frozen and the wrong-path slot squashed until resolve.
      if (!Resolve_Valid) begin
        w_pc_stall = 1'b1;
        w_flush    = 1'b1;
      end
    end else if (w_taken_flush) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_md_hz || w_data_hz ||
                 ((r_state == CTRL_WAIT) && ID_Valid && ID_IsCtrl)) begin
      w_pc_stall   = 1'b1;
      w_ifid_stall = 1'b1;
      w_bubble     = 1'b1;
    end else if (ID_Valid && ID_IsCtrl) begin
      w_go_wait = 1'b1;
    end else if (ID_Valid && ID_IsMulDiv) begin
      w_md_issue = 1'b1;
    end
  end

  assign PC_Stall     = w_pc_stall   & ~Reset;
  assign IF_ID_Stall  = w_ifid_stall & ~Reset;
  assign IF_ID_Flush  = w_flush      & ~Reset;
  assign ID_EX_Bubble = w_bubble     & ~Reset;
  assign Err_Timeout  = w_timeout    & ~Reset;
  assign Stall_Cycles = r_stall_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= RUN;
      r_wd_cnt    <= '0;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_md_issue) begin
        r_md_cnt <= MD_W'(MD_LAT - 1);
      end else if (r_md_cnt != '0) begin
        r_md_cnt <= r_md_cnt - 1'b1;
      end

      if (r_state == RUN) begin
        if (w_go_wait) begin
          r_state  <= CTRL_WAIT;
          r_wd_cnt <= WD_W'(WD_LOAD);
        end
      end else if (Resolve_Valid || w_timeout) begin
        r_state  <= RUN;
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt - 1'b1;
      end

      if (w_pc_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_ctrl;
    logic       is_md;
    logic       reads_hilo;
    logic       ex_valid;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] ex_rd;
    logic       mem_valid;
    logic       mem_rw;
    logic [4:0] mem_rd;
    logic       res_v;
    logic       res_t;
  } in_t;

  typedef struct {
    string       tag;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [15:0] ca;
    logic [2:0]  cb;
  } exp_t;

  // Output vectors are {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Bubble, Err_Timeout}.
  localparam logic [4:0] Z   = 5'b00000;
  localparam logic [4:0] STL = 5'b11010;
  localparam logic [4:0] FRZ = 5'b10100;
  localparam logic [4:0] TKN = 5'b00110;
  localparam logic [4:0] TOA = 5'b10101;
  localparam logic [4:0] TOB = 5'b00001;

  logic Clk = 1'b0;
  in_t  s;
  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] m_cnt_a;
  logic [2:0]  m_cnt_b;

  logic        pc_a, ifs_a, fl_a, bub_a, to_a;
  logic        pc_b, ifs_b, fl_b, bub_b, to_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic [4:0]  o_a, o_b;

  assign o_a = {pc_a, ifs_a, fl_a, bub_a, to_a};
  assign o_b = {pc_b, ifs_b, fl_b, bub_b, to_b};

  always #5 Clk = ~Clk;

  // dut_a: full forwarding, freeze-on-branch. dut_b: no forwarding, predict not-taken, 3-bit counter.
  pipeline_hazard_ctrl #(.RA_W(5), .FWD_EN(1), .BR_MODE(0), .BR_LAT(2), .MD_LAT(4), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(s.rst), .ID_Valid(s.id_valid), .ID_Rs(s.rs), .ID_Rt(s.rt),
    .ID_UsesRs(s.uses_rs), .ID_UsesRt(s.uses_rt), .ID_IsCtrl(s.is_ctrl),
    .ID_IsMulDiv(s.is_md), .ID_ReadsHiLo(s.reads_hilo), .EX_Valid(s.ex_valid),
    .EX_RegWrite(s.ex_rw), .EX_MemRead(s.ex_mr), .EX_Rd(s.ex_rd), .MEM_Valid(s.mem_valid),
    .MEM_RegWrite(s.mem_rw), .MEM_Rd(s.mem_rd), .Resolve_Valid(s.res_v),
    .Resolve_Taken(s.res_t), .PC_Stall(pc_a), .IF_ID_Stall(ifs_a), .IF_ID_Flush(fl_a),
    .ID_EX_Bubble(bub_a), .Err_Timeout(to_a), .Stall_Cycles(cnt_a)
  );

  pipeline_hazard_ctrl #(.RA_W(5), .FWD_EN(0), .BR_MODE(1), .BR_LAT(2), .MD_LAT(4), .CNT_W(3)) dut_b (
    .Clk(Clk), .Reset(s.rst), .ID_Valid(s.id_valid), .ID_Rs(s.rs), .ID_Rt(s.rt),
    .ID_UsesRs(s.uses_rs), .ID_UsesRt(s.uses_rt), .ID_IsCtrl(s.is_ctrl),
    .ID_IsMulDiv(s.is_md), .ID_ReadsHiLo(s.reads_hilo), .EX_Valid(s.ex_valid),
    .EX_RegWrite(s.ex_rw), .EX_MemRead(s.ex_mr), .EX_Rd(s.ex_rd), .MEM_Valid(s.mem_valid),
    .MEM_RegWrite(s.mem_rw), .MEM_Rd(s.mem_rd), .Resolve_Valid(s.res_v),
    .Resolve_Taken(s.res_t), .PC_Stall(pc_b), .IF_ID_Stall(ifs_b), .IF_ID_Flush(fl_b),
    .ID_EX_Bubble(bub_b), .Err_Timeout(to_b), .Stall_Cycles(cnt_b)
  );

  function automatic in_t id(logic ctrl, logic md, logic hilo, logic [4:0] rs, logic [4:0] rt,
                             logic urs, logic urt);
    in_t v = '0;
    v.id_valid = 1'b1; v.is_ctrl = ctrl; v.is_md = md; v.reads_hilo = hilo;
    v.rs = rs; v.rt = rt; v.uses_rs = urs; v.uses_rt = urt;
    return v;
  endfunction

  function automatic in_t ex(in_t v, logic [4:0] rd, logic mr);
    v.ex_valid = 1'b1; v.ex_rw = 1'b1; v.ex_mr = mr; v.ex_rd = rd;
    return v;
  endfunction

  function automatic in_t mem(in_t v, logic [4:0] rd);
    v.mem_valid = 1'b1; v.mem_rw = 1'b1; v.mem_rd = rd;
    return v;
  endfunction

  function automatic in_t res(in_t v, logic taken);
    v.res_v = 1'b1; v.res_t = taken;
    return v;
  endfunction

  // Drives one cycle of stimulus and pushes its expectations; the stall
  // counters are modelled as saturating sums of the expected PC_Stall bits.
  task automatic apply(string tag, in_t v, logic [4:0] ea, logic [4:0] eb);
    s = v;
    if (v.rst) begin
      m_cnt_a = '0;
      m_cnt_b = '0;
    end
    sb.push_back('{tag, ea, eb, m_cnt_a, m_cnt_b});
    if (!v.rst) begin
      if (ea[4] && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
      if (eb[4] && m_cnt_b != 3'd7)     m_cnt_b = m_cnt_b + 3'd1;
    end
  endtask

  task automatic do_reset();
    s = '0;
    s.rst = 1'b1;
    @(posedge Clk); #1;
    s.rst = 1'b0;
    m_cnt_a = '0;
    m_cnt_b = '0;
  endtask

  task automatic test_reset();
    in_t v[4];
    logic [4:0] ea[4], eb[4];
    v[0] = ex(id(0,0,0,8,0,1,0), 8, 1); v[0].rst = 1'b1; ea[0] = Z;   eb[0] = Z;
    v[1] = v[0];                                         ea[1] = Z;   eb[1] = Z;
    v[2] = v[0]; v[2].rst = 1'b0;                        ea[2] = STL; eb[2] = STL;
    v[3] = '0;                                           ea[3] = Z;   eb[3] = Z;
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("reset[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t v[6];
    logic [4:0] ea[6], eb[6];
    do_reset();
    v[0] = ex(id(0,0,0,8,0,1,0), 8, 1); ea[0] = STL; eb[0] = STL;
    v[1] = ex(id(0,0,0,0,0,1,0), 0, 1); ea[1] = Z;   eb[1] = Z;
    v[2] = ex(id(0,0,0,8,0,1,0), 8, 0); ea[2] = Z;   eb[2] = STL;
    v[3] = ex(id(0,0,0,8,0,0,0), 8, 1); ea[3] = Z;   eb[3] = Z;
    v[4] = ex(id(0,0,0,3,8,0,1), 8, 1); ea[4] = STL; eb[4] = STL;
    v[5] = ex('0, 8, 1);                ea[5] = Z;   eb[5] = Z;
    for (int i = 0; i < 6; i++) begin
      apply($sformatf("load_use[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_mem_raw();
    in_t v[4];
    logic [4:0] ea[4], eb[4];
    do_reset();
    v[0] = mem(id(0,0,0,0,9,0,1), 9); ea[0] = Z; eb[0] = STL;
    v[1] = mem(id(0,0,0,0,0,0,1), 0); ea[1] = Z; eb[1] = Z;
    v[2] = mem(id(0,0,0,9,7,1,1), 9); ea[2] = Z; eb[2] = STL;
    v[3] = v[0]; v[3].mem_valid = 1'b0; ea[3] = Z; eb[3] = Z;
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("mem_raw[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch_stall();
    in_t v[5];
    logic [4:0] ea[5], eb[5];
    do_reset();
    v[0] = id(1,0,0,0,0,0,0); ea[0] = Z;   eb[0] = Z;
    v[1] = '0;                ea[1] = FRZ; eb[1] = Z;
    v[2] = '0;                ea[2] = FRZ; eb[2] = Z;
    v[3] = res('0, 1);        ea[3] = Z;   eb[3] = TKN;
    v[4] = '0;                ea[4] = Z;   eb[4] = Z;
    for (int i = 0; i < 5; i++) begin
      apply($sformatf("branch_stall[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch_pnt();
    in_t v[9];
    logic [4:0] ea[9], eb[9];
    do_reset();
    v[0] = id(1,0,0,0,0,0,0);                   ea[0] = Z;   eb[0] = Z;
    v[1] = v[0];                                ea[1] = FRZ; eb[1] = STL;
    v[2] = v[0];                                ea[2] = FRZ; eb[2] = STL;
    v[3] = res('0, 0);                          ea[3] = Z;   eb[3] = Z;
    v[4] = v[0];                                ea[4] = Z;   eb[4] = Z;
    v[5] = res(ex(id(0,0,0,8,0,1,0), 8, 1), 1); ea[5] = Z;   eb[5] = TKN;
    v[6] = '0;                                  ea[6] = Z;   eb[6] = Z;
    v[7] = res('0, 1);                          ea[7] = Z;   eb[7] = TKN;
    v[8] = '0;                                  ea[8] = Z;   eb[8] = Z;
    for (int i = 0; i < 9; i++) begin
      apply($sformatf("branch_pnt[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_muldiv();
    in_t v[12];
    logic [4:0] ea[12], eb[12];
    in_t mult, mfhi, add;
    mult = id(0,1,0,4,5,1,1);
    mfhi = id(0,0,1,0,0,0,0);
    add  = id(0,0,0,1,2,1,1);
    do_reset();
    v[0]  = mult; ea[0]  = Z;   eb[0]  = Z;
    v[1]  = mfhi; ea[1]  = STL; eb[1]  = STL;
    v[2]  = mfhi; ea[2]  = STL; eb[2]  = STL;
    v[3]  = mfhi; ea[3]  = STL; eb[3]  = STL;
    v[4]  = mfhi; ea[4]  = Z;   eb[4]  = Z;
    v[5]  = mult; ea[5]  = Z;   eb[5]  = Z;
    v[6]  = add;  ea[6]  = Z;   eb[6]  = Z;
    v[7]  = mult; ea[7]  = STL; eb[7]  = STL;
    v[8]  = '0;   ea[8]  = Z;   eb[8]  = Z;
    v[9]  = mult; ea[9]  = Z;   eb[9]  = Z;
    v[10] = mfhi; v[10].rst = 1'b1; ea[10] = Z; eb[10] = Z;
    v[11] = mfhi; ea[11] = Z;   eb[11] = Z;
    for (int i = 0; i < 12; i++) begin
      apply($sformatf("muldiv[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_timeout_reset();
    in_t v[11];
    logic [4:0] ea[11], eb[11];
    do_reset();
    v[0] = id(1,0,0,0,0,0,0); ea[0] = Z; eb[0] = Z;
    for (int i = 1; i < 5; i++) begin
      v[i] = '0; ea[i] = FRZ; eb[i] = Z;
    end
    v[5]  = '0;   ea[5]  = TOA; eb[5]  = TOB;
    v[6]  = v[0]; ea[6]  = Z;   eb[6]  = Z;
    v[7]  = '0;   ea[7]  = FRZ; eb[7]  = Z;
    v[8]  = '0;   v[8].rst = 1'b1; ea[8] = Z; eb[8] = Z;
    v[9]  = '0;   ea[9]  = Z;   eb[9]  = Z;
    v[10] = v[0]; ea[10] = Z;   eb[10] = Z;
    for (int i = 0; i < 11; i++) begin
      apply($sformatf("timeout[%0d]", i), v[i], ea[i], eb[i]);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_saturation();
    in_t v;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      v = (i < 11) ? ex(id(0,0,0,8,0,1,0), 8, 1) : in_t'('0);
      apply($sformatf("saturate[%0d]", i), v, (i < 11) ? STL : Z, (i < 11) ? STL : Z);
      #3;
      e = sb.pop_front();
      n_checks += 4;
      if (o_a !== e.a) begin n_errors++; $display("FAIL %s dut_a outs=%b expected=%b", e.tag, o_a, e.a); end
      if (o_b !== e.b) begin n_errors++; $display("FAIL %s dut_b outs=%b expected=%b", e.tag, o_b, e.b); end
      if (cnt_a !== e.ca) begin n_errors++; $display("FAIL %s dut_a Stall_Cycles=%0d expected=%0d", e.tag, cnt_a, e.ca); end
      if (cnt_b !== e.cb) begin n_errors++; $display("FAIL %s dut_b Stall_Cycles=%0d expected=%0d", e.tag, cnt_b, e.cb); end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    s = '0;
    s.rst = 1'b1;
    m_cnt_a = '0;
    m_cnt_b = '0;
    @(posedge Clk); #1;
    test_reset();
    test_load_use();
    test_mem_raw();
    test_branch_stall();
    test_branch_pnt();
    test_muldiv();
    test_timeout_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
